acc_bank_ctrl: RTL and testbench
================================

Name:
acc_bank_ctrl

Overview:
- Sequencer for the row of single-column accumulator banks (one bank per systolic-array column, all sharing one address, write-enable and mode bus).
- Over a programmed number of K-tiles, steps the bank address across M output rows, selecting overwrite for the first K-tile and accumulate for later ones.
- Then drains every row to the downstream requantiser through a valid/ready handshake.
- Sits between the GEMM tile scheduler (cfg/start) and the bank array plus output stage.

Parameters:
DEPTH_LOG2, 8, bank address width; depth 2^DEPTH_LOG2 (256 ≥ 197 tokens)
KT_W, 12, width of the K-tile count field

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle pulse; samples cfg_rows_m1/cfg_kt_m1; ignored unless IDLE
cfg_rows_m1  in  DEPTH_LOG2  output rows minus 1 (0..2^DEPTH_LOG2-1)
cfg_kt_m1  in  KT_W  K-tiles minus 1
psum_valid  in  1  array presents one row of partial sums this cycle
bank_addr  out  DEPTH_LOG2  shared bank address
bank_wr_en  out  1  shared bank write enable
bank_acc_mode  out  1  0 overwrite, 1 accumulate
drain_valid  out  1  bank out_acc at bank_addr is a valid result row
drain_ready  in  1  downstream accepts the row
drain_last  out  1  qualifies the final drained row
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at end of drain
psum_err  out  1  sticky; psum_valid seen outside ACCUM; cleared by cfg_start

Behaviour:
- Reset (async, rst_n=0): state IDLE; all counters 0; bank_addr=0; bank_wr_en=0; bank_acc_mode=0; drain_valid=0; drain_last=0; busy=0; done=0; psum_err=0. Reset mid-run aborts immediately, with no further writes.
- Registered state and counters: rows_m1_q, kt_m1_q, row_cnt, kt_cnt. Bank outputs are combinational from state/counters/psum_valid, so a write lands on the same edge as psum_valid.
- IDLE:
  - cfg_start → latch cfg, clear counters and psum_err, go to ACCUM next cycle.
- ACCUM:
  - bank_addr = row_cnt.
  - bank_wr_en = psum_valid.
  - bank_acc_mode = (kt_cnt != 0).
  - On psum_valid: row_cnt increments. At row_cnt == rows_m1_q it wraps to 0 and kt_cnt increments.
  - psum_valid low: hold, no write.
  - Last write (row_cnt == rows_m1_q && kt_cnt == kt_m1_q) → DRAIN with row_cnt=0.
- DRAIN:
  - bank_wr_en = 0; bank_addr = row_cnt; drain_valid = 1.
  - drain_last = (row_cnt == rows_m1_q).
  - Bank read is asynchronous, so the data is valid the same cycle.
  - Advance only on drain_valid && drain_ready. With drain_ready low, bank_addr and drain_valid hold stable.
  - Accepted last row → DONE.
- DONE: done=1 for one cycle, busy still 1 → IDLE.
- cfg_start while busy: ignored, no effect on config.
- psum_valid in IDLE, DRAIN or DONE: no write; psum_err set.
- cfg_rows_m1=0 and/or cfg_kt_m1=0 are legal (single row and/or single K-tile).
- Full-depth case rows_m1 = 2^DEPTH_LOG2-1 needs no extra address bit.
- Latency:
  - start → first possible write: 1 cycle.
  - Last write → drain_valid: 1 cycle.
  - Minimum total: (rows×kt) + rows + 2 cycles with psum_valid and drain_ready held high.

Optional Feature:
ACC_CTRL_PERF_EN
- Defined: adds outputs perf_idle_cyc[31:0] and perf_stall_cyc[31:0], both cleared on cfg_start and saturating at all-ones.
  - perf_idle_cyc counts ACCUM cycles with psum_valid=0.
  - perf_stall_cyc counts DRAIN cycles with drain_ready=0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared params header: state encodings (IDLE, ACCUM, DRAIN, DONE) and the existing ACC_WIDTH.
- The DEPTH_LOG2 default comes from the same header so bank and controller always agree.
- No sub-module: counters and FSM stay in one file (about 150–250 lines).

Test Plan:
- rows_m1=3, kt_m1=0, psum_valid held high → writes addr 0,1,2,3 with acc_mode=0; drain 4 rows with ready high; drain_last on addr 3; done 1 cycle later.
- rows_m1=2, kt_m1=2, psum values 1 per write → kt0 overwrites, kt1/kt2 accumulate; bank model drains 3,3,3.
- Drain with drain_ready toggling 1,0,0,1 → bank_addr and drain_valid hold during 0s; every row is taken exactly once.
- psum_valid pulsed in IDLE → no bank_wr_en, psum_err=1; next cfg_start clears it.
- rst_n asserted mid-ACCUM (row_cnt=5) → outputs go to reset values immediately; a new cfg_start runs cleanly from addr 0.
- rows_m1=255, kt_m1=1 → addr wraps 255→0 between K-tiles with acc_mode rising; drain covers all 256 rows. cfg_start while busy is ignored.

Source files
------------

// File: rtl/acc_bank_ctrl_pkg.sv
// Shared parameters for the accumulator bank row and its sequencer: bank depth,
// accumulator width and the controller state encodings.
package acc_bank_ctrl_pkg;

  localparam int ACC_DEPTH_LOG2 = 8;
  localparam int ACC_KT_W       = 12;
  localparam int ACC_WIDTH      = 32;

  // Kept as plain constants so older bank-side code can compare against them.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/acc_bank_ctrl.sv
// Accumulator bank sequencer: steps K-tiles over M rows, then drains the rows downstream.
// Optional ACC_CTRL_PERF_EN adds saturating idle/stall performance counters.
module acc_bank_ctrl
  import acc_bank_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2 = ACC_DEPTH_LOG2,
  parameter int KT_W       = ACC_KT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [DEPTH_LOG2-1:0] cfg_rows_m1,
  input  logic [KT_W-1:0]       cfg_kt_m1,
  input  logic                  psum_valid,
  output logic [DEPTH_LOG2-1:0] bank_addr,
  output logic                  bank_wr_en,
  output logic                  bank_acc_mode,
  output logic                  drain_valid,
  input  logic                  drain_ready,
  output logic                  drain_last,
  output logic                  busy,
  output logic                  done,
  output logic                  psum_err
`ifdef ACC_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_idle_cyc,
  output logic [31:0]           perf_stall_cyc
`endif
);

  logic [1:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] rows_m1_q, rows_m1_d;
  logic [KT_W-1:0]       kt_m1_q, kt_m1_d;
  logic [DEPTH_LOG2-1:0] row_cnt_q, row_cnt_d;
  logic [KT_W-1:0]       kt_cnt_q, kt_cnt_d;
  logic                  psum_err_q, psum_err_d;

  logic start_accept;
  logic row_at_end;
  logic kt_at_end;

  assign start_accept = (state_q == ST_IDLE) && cfg_start;
  assign row_at_end   = (row_cnt_q == rows_m1_q);
  assign kt_at_end    = (kt_cnt_q == kt_m1_q);

  // Bank controls are combinational so a write lands on the same edge as psum_valid.
  assign bank_addr     = row_cnt_q;
  assign bank_wr_en    = (state_q == ST_ACCUM) && psum_valid;
  assign bank_acc_mode = (state_q == ST_ACCUM) && (kt_cnt_q != '0);
  assign drain_valid   = (state_q == ST_DRAIN);
  assign drain_last    = (state_q == ST_DRAIN) && row_at_end;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign psum_err      = psum_err_q;

  always_comb begin
    state_d    = state_q;
    rows_m1_d  = rows_m1_q;
    kt_m1_d    = kt_m1_q;
    row_cnt_d  = row_cnt_q;
    kt_cnt_d   = kt_cnt_q;
    psum_err_d = psum_err_q;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          rows_m1_d  = cfg_rows_m1;
          kt_m1_d    = cfg_kt_m1;
          row_cnt_d  = '0;
          kt_cnt_d   = '0;
          psum_err_d = 1'b0;
          state_d    = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (psum_valid) begin
          if (row_at_end) begin
            row_cnt_d = '0;
            if (kt_at_end) begin
              kt_cnt_d = '0;
              state_d  = ST_DRAIN;
            end else begin
              kt_cnt_d = kt_cnt_q + 1'b1;
            end
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_ready) begin
          if (row_at_end) begin
            row_cnt_d = '0;
            state_d   = ST_DONE;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A stray row outside ACCUM is flagged even if it coincides with a start.
    if (psum_valid && (state_q != ST_ACCUM)) begin
      psum_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rows_m1_q  <= '0;
      kt_m1_q    <= '0;
      row_cnt_q  <= '0;
      kt_cnt_q   <= '0;
      psum_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_m1_q  <= rows_m1_d;
      kt_m1_q    <= kt_m1_d;
      row_cnt_q  <= row_cnt_d;
      kt_cnt_q   <= kt_cnt_d;
      psum_err_q <= psum_err_d;
    end
  end

`ifdef ACC_CTRL_PERF_EN
  logic [31:0] idle_cyc_q, stall_cyc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cyc_q  <= '0;
      stall_cyc_q <= '0;
    end else if (start_accept) begin
      idle_cyc_q  <= '0;
      stall_cyc_q <= '0;
    end else begin
      if ((state_q == ST_ACCUM) && !psum_valid && (idle_cyc_q != '1)) begin
        idle_cyc_q <= idle_cyc_q + 1'b1;
      end
      if ((state_q == ST_DRAIN) && !drain_ready && (stall_cyc_q != '1)) begin
        stall_cyc_q <= stall_cyc_q + 1'b1;
      end
    end
  end

  assign perf_idle_cyc  = idle_cyc_q;
  assign perf_stall_cyc = stall_cyc_q;
`else
  logic unused_start;
  assign unused_start = start_accept;
`endif

endmodule

// File: tb/tb_acc_bank_ctrl.sv
// Self-checking bench for acc_bank_ctrl: a bank memory model plus per-row expected
// sums derived from the row/K-tile schedule, driven with randomized psum/ready traffic.
module tb_acc_bank_ctrl;
  import acc_bank_ctrl_pkg::*;

  localparam int DW       = ACC_DEPTH_LOG2;
  localparam int KW       = ACC_KT_W;
  localparam int ROWS_MAX = 1 << DW;
  localparam int BUDGET   = 20000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start;
  logic [DW-1:0] cfg_rows_m1;
  logic [KW-1:0] cfg_kt_m1;
  logic          psum_valid;
  logic [DW-1:0] bank_addr;
  logic          bank_wr_en;
  logic          bank_acc_mode;
  logic          drain_valid;
  logic          drain_ready;
  logic          drain_last;
  logic          busy;
  logic          done;
  logic          psum_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [ACC_WIDTH-1:0] bankMem [ROWS_MAX];
  logic [ACC_WIDTH-1:0] expSum  [ROWS_MAX];
  logic                 readyPat [4];
  bit                   expErr;

  acc_bank_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_start    (cfg_start),
    .cfg_rows_m1  (cfg_rows_m1),
    .cfg_kt_m1    (cfg_kt_m1),
    .psum_valid   (psum_valid),
    .bank_addr    (bank_addr),
    .bank_wr_en   (bank_wr_en),
    .bank_acc_mode(bank_acc_mode),
    .drain_valid  (drain_valid),
    .drain_ready  (drain_ready),
    .drain_last   (drain_last),
    .busy         (busy),
    .done         (done),
    .psum_err     (psum_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One complete job: rows x kts writes in row-major K-tile order, then a full drain.
  task automatic applyStimulus(input int rowsM1, input int ktM1, input int validPct,
                               input int readyMode, input bit unitData,
                               input bit errInDrain, input bit busyStarts);
    int rows  = rowsM1 + 1;
    int total = rows * (ktM1 + 1);
    int w     = 0;
    int j     = 0;
    int cyc;
    logic [ACC_WIDTH-1:0] d;

    for (int r = 0; r < rows; r++) expSum[r] = '0;

    @(negedge clk);
    cfg_start   = 1'b1;
    cfg_rows_m1 = rowsM1[DW-1:0];
    cfg_kt_m1   = ktM1[KW-1:0];
    psum_valid  = 1'b0;
    drain_ready = 1'b0;
    #1;
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_err", psum_err, expErr);
    @(posedge clk);
    expErr = 0;

    cyc = 0;
    while (w < total && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      cfg_start   = busyStarts && ($urandom_range(0, 9) == 0);
      cfg_rows_m1 = DW'($urandom);
      cfg_kt_m1   = KW'($urandom);
      psum_valid  = ($urandom_range(1, 100) <= validPct);
      d = unitData ? 1 : ACC_WIDTH'($urandom_range(0, 100000));
      #1;
      checkOutput("acc_busy", busy, 1);
      checkOutput("acc_drain_valid", drain_valid, 0);
      checkOutput("acc_done", done, 0);
      checkOutput("acc_wr_en", bank_wr_en, psum_valid);
      checkOutput("acc_err", psum_err, expErr);
      if (psum_valid) begin
        checkOutput("acc_addr", bank_addr, w % rows);
        checkOutput("acc_mode", bank_acc_mode, (w / rows) != 0);
        expSum[w % rows] += d;
        if (bank_wr_en) bankMem[bank_addr] = bank_acc_mode ? bankMem[bank_addr] + d : d;
        w++;
      end
      @(posedge clk);
    end
    if (w < total) begin
      checkOutput("acc_timeout", w, total);
      return;
    end

    cyc = 0;
    while (j < rows && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      cfg_start   = busyStarts && ($urandom_range(0, 9) == 0);
      cfg_rows_m1 = DW'($urandom);
      cfg_kt_m1   = KW'($urandom);
      psum_valid  = errInDrain && (cyc == 1);
      case (readyMode)
        0:       drain_ready = 1'b1;
        1:       drain_ready = 1'($urandom_range(0, 1));
        default: drain_ready = readyPat[(cyc - 1) % 4];
      endcase
      #1;
      checkOutput("drn_busy", busy, 1);
      checkOutput("drn_valid", drain_valid, 1);
      checkOutput("drn_wr_en", bank_wr_en, 0);
      checkOutput("drn_done", done, 0);
      checkOutput("drn_addr", bank_addr, j);
      checkOutput("drn_last", drain_last, j == rows - 1);
      checkOutput("drn_data", bankMem[bank_addr], expSum[j]);
      checkOutput("drn_err", psum_err, expErr);
      if (psum_valid) expErr = 1;
      if (drain_ready) j++;
      @(posedge clk);
    end
    if (j < rows) begin
      checkOutput("drn_timeout", j, rows);
      return;
    end

    @(negedge clk);
    cfg_start   = 1'b0;
    psum_valid  = 1'b0;
    drain_ready = 1'b0;
    #1;
    checkOutput("done_pulse", done, 1);
    checkOutput("done_busy", busy, 1);
    checkOutput("done_drain_valid", drain_valid, 0);
    checkOutput("done_err", psum_err, expErr);
    @(negedge clk);
    #1;
    checkOutput("post_done", done, 0);
    checkOutput("post_busy", busy, 0);
  endtask

  initial begin
    readyPat[0] = 1'b1;
    readyPat[1] = 1'b0;
    readyPat[2] = 1'b0;
    readyPat[3] = 1'b1;
    for (int i = 0; i < ROWS_MAX; i++) bankMem[i] = '0;
    expErr      = 0;
    rst_n       = 1'b0;
    cfg_start   = 1'b0;
    cfg_rows_m1 = '0;
    cfg_kt_m1   = '0;
    psum_valid  = 1'b0;
    drain_ready = 1'b0;

    #12;
    checkOutput("rst_addr", bank_addr, 0);
    checkOutput("rst_wr_en", bank_wr_en, 0);
    checkOutput("rst_mode", bank_acc_mode, 0);
    checkOutput("rst_drain_valid", drain_valid, 0);
    checkOutput("rst_drain_last", drain_last, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", psum_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] four rows, single K-tile, free-running");
    applyStimulus(3, 0, 100, 0, 0, 0, 0);

    $display("[TB] three rows, three K-tiles, unit data");
    applyStimulus(2, 2, 100, 0, 1, 0, 0);

    $display("[TB] drain with ready pattern 1,0,0,1");
    applyStimulus(5, 1, 100, 2, 0, 0, 0);

    $display("[TB] psum_valid in IDLE");
    @(negedge clk);
    psum_valid = 1'b1;
    #1;
    checkOutput("idle_pv_wr_en", bank_wr_en, 0);
    checkOutput("idle_pv_err_before", psum_err, 0);
    expErr = 1;
    @(negedge clk);
    psum_valid = 1'b0;
    #1;
    checkOutput("idle_pv_err_after", psum_err, 1);
    applyStimulus(1, 1, 70, 1, 0, 0, 0);

    $display("[TB] reset mid-ACCUM");
    @(negedge clk);
    cfg_start   = 1'b1;
    cfg_rows_m1 = DW'(9);
    cfg_kt_m1   = KW'(1);
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      psum_valid = 1'b1;
      #1;
      checkOutput("pre_rst_addr", bank_addr, i);
      @(negedge clk);
    end
    #1;
    checkOutput("pre_rst_addr5", bank_addr, 5);
    checkOutput("pre_rst_wr_en", bank_wr_en, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_wr_en", bank_wr_en, 0);
    checkOutput("mid_rst_addr", bank_addr, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_drain_valid", drain_valid, 0);
    checkOutput("mid_rst_err", psum_err, 0);
    @(negedge clk);
    psum_valid = 1'b0;
    rst_n      = 1'b1;
    expErr     = 0;
    applyStimulus(6, 0, 80, 1, 0, 0, 0);

    $display("[TB] full depth, two K-tiles, ignored restarts");
    applyStimulus(ROWS_MAX - 1, 1, 75, 1, 0, 0, 1);

    $display("[TB] psum_valid during DRAIN");
    applyStimulus(2, 0, 100, 0, 0, 1, 0);

    $display("[TB] single row, single K-tile");
    applyStimulus(0, 0, 100, 0, 0, 0, 0);

    $display("[TB] random jobs");
    for (int n = 0; n < 6; n++) begin
      applyStimulus($urandom_range(0, 15), $urandom_range(0, 3), 60, 1, 0, 0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
